gcd_job_arbiter: RTL and testbench
==================================

// Module: gcd_job_arbiter
// PURPOSE
//  Shares one GCD datapath between NUM_REQ requesters.
//  Picks a pending request round-robin, latches its operands, and pulses the datapath start.
//  Waits for the datapath done, then returns the result tagged with the requester ID.
//  Sits between client logic and the gcd datapath/controller pair.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  WIDTH     8    operand/result width in bits
//  WDT_CYC   255  watchdog limit in cycles (used only with GCD_WDT_EN)
// PORTS
//  clk         in   1               single clock, rising edge
//  rst_n       in   1               asynchronous, active-low reset
//  req         in   NUM_REQ         per-requester request level, held until gnt
//  a_in        in   NUM_REQ*WIDTH   operand A, slice i for requester i
//  b_in        in   NUM_REQ*WIDTH   operand B, slice i for requester i
//  gnt         out  NUM_REQ         one-hot, 1-cycle pulse: operands of req i captured
//  rsp_valid   out  1               result available; held until rsp_ready
//  rsp_ready   in   1               consumer accepts result
//  rsp_id      out  $clog2(NUM_REQ) requester index of the result
//  rsp_result  out  WIDTH           gcd(A,B)
//  rsp_err     out  1               result invalid (watchdog expired); 0 without GCD_WDT_EN
//  dp_start    out  1               1-cycle start pulse to datapath
//  dp_a, dp_b  out  WIDTH           operands to datapath, stable from dp_start until dp_done
//  dp_done     in   1               datapath finished (level or pulse; sampled in WAIT only)
//  dp_result   in   WIDTH           datapath result, valid while dp_done=1
//  busy        out  1               1 in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0; gnt, dp_start, rsp_valid, rsp_err, busy all 0; rsp_id, rsp_result, dp_a, dp_b = 0.
//  FSM states: IDLE -> GRANT -> LAUNCH -> WAIT -> RESP -> IDLE.
//  IDLE: if |req, go to GRANT.
//  GRANT: pick the first set req at or after rr_ptr (wrapping).
//   Pulse gnt[i]; latch a_in[i], b_in[i] into dp_a/dp_b; latch id.
//   Set rr_ptr = i+1, wrapping to 0 past NUM_REQ-1.
//  LAUNCH:
//   If dp_a==0 or dp_b==0, bypass the datapath: result = dp_a|dp_b (gcd(0,0)=0); go to RESP with no dp_start.
//   Else pulse dp_start for 1 cycle; go to WAIT.
//  WAIT: on dp_done=1, latch dp_result; go to RESP.
//  RESP:
//   rsp_valid=1 with rsp_id and rsp_result stable.
//   When rsp_valid && rsp_ready: clear rsp_valid in the next cycle; go to IDLE.
//  Latency: req to gnt = 2 cycles from IDLE. gnt to dp_start = 1 cycle. dp_done to rsp_valid = 1 cycle.
//  Zero bypass: gnt to rsp_valid = 2 cycles.
//  Only one job is in flight at a time. New req is ignored until the FSM returns to IDLE (no back-to-back overlap).
//  A req that drops before its grant is lost and not reported.
//  dp_done seen outside WAIT is ignored.
//  Reset mid-job: the job is abandoned. No gnt or rsp is produced for it, and the requester must re-request.
//  All outputs are registered.
// CONFIGURATION
//  GCD_WDT_EN defined:
//   WAIT counts cycles.
//   If the count reaches WDT_CYC with no dp_done, go to RESP with rsp_err=1 and rsp_result=0.
//   The counter clears on entry to WAIT.
//  GCD_WDT_EN undefined:
//   There is no counter, and WAIT waits indefinitely.
//   rsp_err is tied to 0.
// STRUCTURE
//  Package gcd_pkg holds:
//   the state enum (IDLE, GRANT, LAUNCH, WAIT, RESP), 3 bits;
//   the default WIDTH and NUM_REQ constants.
//  Sub-module rr_picker (combinational): takes req and rr_ptr, returns a one-hot grant and an index.
//  The FSM, operand latches and watchdog stay in this module.
// TESTING
//  T1: NUM_REQ=4; req=0001, A=48, B=18 -> gnt[0] pulse, dp_start, model done -> rsp_id=0, rsp_result=6.
//  T2: req=1111 held; serve 4 jobs -> grant order 0,1,2,3,0; rr_ptr wraps correctly.
//  T3: A=0, B=35 -> no dp_start; rsp_result=35 two cycles after gnt. A=0, B=0 -> rsp_result=0.
//  T4: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id, rsp_result held; req from another client is not granted until accept.
//  T5: rst_n low during WAIT -> all outputs 0 immediately; no rsp follows; next req is served from rr_ptr=0.
//  T6 (GCD_WDT_EN, WDT_CYC=10): dp_done never asserted -> rsp_valid with rsp_err=1, rsp_result=0, then IDLE.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job arbiter: FSM state encoding,
// default geometry and the requester-index width helper.
package gcd_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_WDT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Index width of a requester ID; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_job_arbiter_if.sv
// Bundle of client-side and datapath-side signals of the GCD job arbiter.
// The arbiter uses the slave modport; the environment (clients + datapath) uses master.
interface gcd_job_arbiter_if
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  localparam int IDW = id_width(NUM_REQ);

  // Handshakes: req[i] is a level held until gnt[i] pulses (operands captured
  // on that pulse). rsp_valid is held with rsp_id/rsp_result/rsp_err stable
  // until a cycle with rsp_valid && rsp_ready, which is the transfer cycle.
  // dp_start is a one-cycle pulse; dp_done/dp_result are sampled only while
  // the arbiter is waiting on the datapath.
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_err;
  logic                     dp_start;
  logic [WIDTH-1:0]         dp_a;
  logic [WIDTH-1:0]         dp_b;
  logic                     dp_done;
  logic [WIDTH-1:0]         dp_result;

  modport slave (
    input  req, a_in, b_in, rsp_ready, dp_done, dp_result,
    output gnt, rsp_valid, rsp_id, rsp_result, rsp_err, dp_start, dp_a, dp_b
  );

  modport master (
    output req, a_in, b_in, rsp_ready, dp_done, dp_result,
    input  gnt, rsp_valid, rsp_id, rsp_result, rsp_err, dp_start, dp_a, dp_b
  );

endinterface

// File: rtl/gcd_job_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping, returned as a one-hot vector and an index.
module rr_picker
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_any
);

  logic [IDW-1:0] cand [NUM_REQ];

  // cand[k] is the k-th requester in priority order starting from rr_ptr.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cand[k] = IDW'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req[cand[k]]) begin
        gnt_any          = 1'b1;
        gnt_idx          = cand[k];
        gnt_oh[cand[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one GCD datapath among NUM_REQ requesters, one job in flight at a time.
// Define GCD_WDT_EN to add a WAIT-state watchdog that reports rsp_err after WDT_CYC cycles.
module gcd_job_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WDT_CYC = DEF_WDT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  gcd_job_arbiter_if.slave  bus,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int IDW = id_width(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]     dp_a_q, dp_a_d;
  logic [WIDTH-1:0]     dp_b_q, dp_b_d;
  logic                 dp_start_q, dp_start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;

`ifdef GCD_WDT_EN
  localparam int WCW = $clog2(WDT_CYC + 1);
  logic [WCW-1:0]       wdt_cnt_q, wdt_cnt_d;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = '0;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_start_d   = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
`ifdef GCD_WDT_EN
    wdt_cnt_d    = wdt_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (|bus.req) state_d = GRANT;
      end

      // A request that vanished between IDLE and GRANT is simply dropped.
      GRANT: begin
        if (pick_any) begin
          gnt_d     = pick_oh;
          dp_a_d    = bus.a_in[int'(pick_idx)*WIDTH +: WIDTH];
          dp_b_d    = bus.b_in[int'(pick_idx)*WIDTH +: WIDTH];
          rsp_id_d  = pick_idx;
          rsp_err_d = 1'b0;
          rr_ptr_d  = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d   = LAUNCH;
        end else begin
          state_d   = IDLE;
        end
      end

      // A zero operand makes the answer the other operand; skip the datapath.
      LAUNCH: begin
        if (dp_a_q == '0 || dp_b_q == '0) begin
          rsp_result_d = dp_a_q | dp_b_q;
          state_d      = RESP;
        end else begin
          dp_start_d   = 1'b1;
          state_d      = WAIT;
`ifdef GCD_WDT_EN
          wdt_cnt_d    = '0;
`endif
        end
      end

      WAIT: begin
        if (bus.dp_done) begin
          rsp_result_d = bus.dp_result;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
`ifdef GCD_WDT_EN
        else if (wdt_cnt_q + 1'b1 == WCW'(WDT_CYC)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          wdt_cnt_d    = wdt_cnt_q + 1'b1;
        end
`endif
      end

      // Bypass enters RESP with rsp_valid still low; it rises one cycle later.
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_start_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_start_q   <= dp_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef GCD_WDT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdt_cnt_q <= '0;
    else        wdt_cnt_q <= wdt_cnt_d;
  end
`endif

  assign bus.gnt        = gnt_q;
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.dp_start   = dp_start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Self-checking bench for gcd_job_arbiter: random jobs against a round-robin/GCD
// reference model, plus directed reset, bypass, backpressure and mid-job reset cases.
module tb_gcd_job_arbiter;
  import gcd_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int WDT  = 10;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b1;
  logic   busy;
  state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int done_set_cyc = 0;
  int model_ptr = 0;
  int dp_delay_force = -1;
  bit dp_model_en = 1'b1;
  int op_a [NREQ];
  int op_b [NREQ];
  logic [W-1:0] exp_q [$];

  typedef struct {
    bit tmo;
    int gidx;
    int gnt_bits;
    int gnt_lat;
    int busy_at_gnt;
    int start_seen;
    int start_lat;
    int rsp_lat;
    int done_lat;
    int id;
    int res;
    int err;
    int unstable;
    int gnt_in_hold;
    int valid_after;
  } job_obs_t;

  gcd_job_arbiter_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus ();

  gcd_job_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .WDT_CYC(WDT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int gcd_ref(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Datapath stand-in: answers dp_start after a short random delay.
  initial begin
    int d;
    bus.dp_done = 1'b0;
    bus.dp_result = '0;
    forever begin
      @(posedge clk); #2;
      if (bus.dp_start && dp_model_en) begin
        d = (dp_delay_force >= 0) ? dp_delay_force : int'($urandom_range(0, 4));
        for (int k = 0; k < d; k++) begin @(posedge clk); #2; end
        bus.dp_result = W'(gcd_ref(int'(bus.dp_a), int'(bus.dp_b)));
        bus.dp_done = 1'b1;
        done_set_cyc = cyc_cnt;
        @(posedge clk); #2;
        bus.dp_done = 1'b0;
        bus.dp_result = W'($urandom);
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    bus.a_in[i*W +: W] = W'(a);
    bus.b_in[i*W +: W] = W'(b);
    op_a[i] = a;
    op_b[i] = b;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.req = '0;
    bus.rsp_ready = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one request mask, follows the job to its response and accepts it after hold cycles.
  task automatic do_job(input logic [NREQ-1:0] mask, input int hold, output job_obs_t o);
    int cyc, gnt_c, rid, rres, rerr;
    o = '{default: 0};
    o.start_lat = -1;
    bus.req = mask;
    cyc = 0;
    while (bus.gnt == '0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (bus.gnt == '0) begin o.tmo = 1'b1; return; end
    o.gnt_lat = cyc;
    o.gnt_bits = int'(bus.gnt);
    for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) o.gidx = i;
    o.busy_at_gnt = int'(busy);
    gnt_c = cyc_cnt;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (bus.dp_start) begin
        o.start_seen++;
        if (o.start_lat < 0) o.start_lat = cyc_cnt - gnt_c;
      end
    end
    if (!bus.rsp_valid) begin o.tmo = 1'b1; return; end
    o.rsp_lat = cyc_cnt - gnt_c;
    o.done_lat = cyc_cnt - done_set_cyc;
    o.id = int'(bus.rsp_id);
    o.res = int'(bus.rsp_result);
    o.err = int'(bus.rsp_err);
    rid = o.id; rres = o.res; rerr = o.err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != rid || int'(bus.rsp_result) != rres ||
          int'(bus.rsp_err) != rerr) o.unstable++;
      if (bus.gnt != '0) o.gnt_in_hold++;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    o.valid_after = int'(bus.rsp_valid);
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if ({bus.gnt, bus.dp_start, bus.rsp_valid, bus.rsp_err, busy} !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0", {bus.gnt, bus.dp_start, bus.rsp_valid, bus.rsp_err, busy}); end
    checks++; if (bus.rsp_id !== '0 || bus.rsp_result !== '0) begin
      errors++; $display("FAIL reset_rsp got id=%0d res=%0d exp 0/0", bus.rsp_id, bus.rsp_result); end
    checks++; if (bus.dp_a !== '0 || bus.dp_b !== '0) begin
      errors++; $display("FAIL reset_dp got a=%0d b=%0d exp 0/0", bus.dp_a, bus.dp_b); end
    checks++; if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_single();
    job_obs_t o;
    reset_dut();
    set_op(0, 48, 18);
    do_job(4'b0001, 0, o);
    bus.req = '0;
    checks++; if (o.tmo) begin errors++; $display("FAIL t1_timeout got=1 exp=0"); end
    checks++; if (o.gnt_lat != 2) begin errors++; $display("FAIL t1_gnt_lat got=%0d exp=2", o.gnt_lat); end
    checks++; if (o.gnt_bits != 1) begin errors++; $display("FAIL t1_gnt got=%0d exp=1", o.gnt_bits); end
    checks++; if (o.busy_at_gnt != 1) begin errors++; $display("FAIL t1_busy got=%0d exp=1", o.busy_at_gnt); end
    checks++; if (o.start_seen != 1 || o.start_lat != 1) begin
      errors++; $display("FAIL t1_start got seen=%0d lat=%0d exp 1/1", o.start_seen, o.start_lat); end
    checks++; if (o.done_lat != 1) begin errors++; $display("FAIL t1_done_lat got=%0d exp=1", o.done_lat); end
    checks++; if (o.id != 0 || o.res != 6 || o.err != 0) begin
      errors++; $display("FAIL t1_rsp got id=%0d res=%0d err=%0d exp 0/6/0", o.id, o.res, o.err); end
    checks++; if (o.valid_after != 0 || dbg_state !== IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL t1_after got valid=%0d state=%0d busy=%0d exp 0/0/0", o.valid_after, dbg_state, busy); end
  endtask

  task automatic test_round_robin();
    job_obs_t o;
    int order [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(1, 255)), int'($urandom_range(1, 255)));
    for (int j = 0; j < 5; j++) begin
      do_job(4'b1111, 0, o);
      checks++; if (o.tmo || o.gidx != order[j]) begin
        errors++; $display("FAIL t2_order[%0d] got=%0d exp=%0d", j, o.gidx, order[j]); end
      checks++; if (o.res != gcd_ref(op_a[order[j]], op_b[order[j]])) begin
        errors++; $display("FAIL t2_res[%0d] got=%0d exp=%0d", j, o.res, gcd_ref(op_a[order[j]], op_b[order[j]])); end
    end
    bus.req = '0;
  endtask

  task automatic test_zero_bypass();
    job_obs_t o;
    int ia [3] = '{2, 1, 3};
    int aa [3] = '{0, 0, 77};
    int bb [3] = '{35, 0, 0};
    int er [3] = '{35, 0, 77};
    reset_dut();
    for (int j = 0; j < 3; j++) begin
      set_op(ia[j], aa[j], bb[j]);
      do_job(NREQ'(1 << ia[j]), 0, o);
      checks++; if (o.tmo || o.start_seen != 0 || o.rsp_lat != 2) begin
        errors++; $display("FAIL t3_bypass[%0d] got starts=%0d lat=%0d exp 0/2", j, o.start_seen, o.rsp_lat); end
      checks++; if (o.res != er[j] || o.id != ia[j]) begin
        errors++; $display("FAIL t3_rsp[%0d] got res=%0d id=%0d exp %0d/%0d", j, o.res, o.id, er[j], ia[j]); end
    end
    bus.req = '0;
  endtask

  task automatic test_backpressure();
    job_obs_t o;
    reset_dut();
    set_op(0, 21, 14);
    set_op(3, 9, 6);
    do_job(4'b1001, 5, o);
    checks++; if (o.tmo || o.gidx != 0 || o.res != 7) begin
      errors++; $display("FAIL t4_first got g=%0d res=%0d exp 0/7", o.gidx, o.res); end
    checks++; if (o.unstable != 0) begin errors++; $display("FAIL t4_stable got=%0d exp=0", o.unstable); end
    checks++; if (o.gnt_in_hold != 0) begin errors++; $display("FAIL t4_no_gnt got=%0d exp=0", o.gnt_in_hold); end
    checks++; if (o.valid_after != 0) begin errors++; $display("FAIL t4_clear got=%0d exp=0", o.valid_after); end
    do_job(4'b1001, 2, o);
    checks++; if (o.tmo || o.gidx != 3 || o.id != 3 || o.res != 3) begin
      errors++; $display("FAIL t4_second got g=%0d id=%0d res=%0d exp 3/3/3", o.gidx, o.id, o.res); end
    bus.req = '0;
  endtask

  task automatic test_reset_mid_job();
    job_obs_t o;
    int cyc, seen;
    reset_dut();
    set_op(2, 30, 12);
    do_job(4'b0100, 0, o);
    checks++; if (o.tmo || o.gidx != 2 || o.res != 6) begin
      errors++; $display("FAIL t5_pre got g=%0d res=%0d exp 2/6", o.gidx, o.res); end
    bus.req = '0;
    set_op(3, 100, 75);
    dp_delay_force = 20;
    bus.req = 4'b1000;
    cyc = 0;
    while (!bus.dp_start && cyc < 20) begin @(posedge clk); #1; cyc++; end
    checks++; if (bus.dp_start !== 1'b1) begin errors++; $display("FAIL t5_start got=0 exp=1"); end
    bus.req = '0;
    @(posedge clk); #1;
    checks++; if (dbg_state !== WAIT) begin errors++; $display("FAIL t5_in_wait got=%0d exp=%0d", dbg_state, WAIT); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.gnt, bus.dp_start, bus.rsp_valid, bus.rsp_err, busy} !== '0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL t5_async got=%b state=%0d exp 0", {bus.gnt, bus.dp_start, bus.rsp_valid, bus.rsp_err, busy}, dbg_state); end
    checks++; if (bus.dp_a !== '0 || bus.dp_b !== '0 || bus.rsp_result !== '0 || bus.rsp_id !== '0) begin
      errors++; $display("FAIL t5_async_data got a=%0d b=%0d res=%0d id=%0d exp 0", bus.dp_a, bus.dp_b, bus.rsp_result, bus.rsp_id); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_ptr = 0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.gnt != '0 || bus.rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL t5_no_rsp got=%0d exp=0", seen); end
    dp_delay_force = -1;
    set_op(1, 81, 27);
    set_op(3, 64, 48);
    do_job(4'b1010, 0, o);
    checks++; if (o.tmo || o.gidx != 1 || o.res != 27) begin
      errors++; $display("FAIL t5_after got g=%0d res=%0d exp 1/27", o.gidx, o.res); end
    bus.req = '0;
  endtask

  task automatic test_random();
    job_obs_t o;
    logic [NREQ-1:0] mask;
    int eg, hold;
    logic [W-1:0] ev;
    bit zero_op;
    reset_dut();
    for (int j = 0; j < 25; j++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        set_op(i, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255)),
                  ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255)));
      end
      hold = int'($urandom_range(0, 3));
      eg = exp_grant(mask);
      exp_q.push_back(W'(gcd_ref(op_a[eg], op_b[eg])));
      zero_op = (op_a[eg] == 0 || op_b[eg] == 0);
      do_job(mask, hold, o);
      ev = exp_q.pop_front();
      checks++; if (o.tmo || o.gidx != eg || o.gnt_bits != (1 << eg) || o.id != eg) begin
        errors++; $display("FAIL rnd_grant[%0d] got g=%0d bits=%0d id=%0d exp %0d", j, o.gidx, o.gnt_bits, o.id, eg); end
      checks++; if (o.res != int'(ev) || o.err != 0) begin
        errors++; $display("FAIL rnd_result[%0d] got res=%0d err=%0d exp %0d/0", j, o.res, o.err, ev); end
      checks++; if (o.unstable != 0 || o.gnt_in_hold != 0 || o.valid_after != 0) begin
        errors++; $display("FAIL rnd_hold[%0d] got unst=%0d gnt=%0d valid=%0d exp 0", j, o.unstable, o.gnt_in_hold, o.valid_after); end
      if (zero_op) begin
        checks++; if (o.start_seen != 0 || o.rsp_lat != 2) begin
          errors++; $display("FAIL rnd_bypass[%0d] got starts=%0d lat=%0d exp 0/2", j, o.start_seen, o.rsp_lat); end
      end else begin
        checks++; if (o.start_seen != 1 || o.start_lat != 1 || o.done_lat != 1) begin
          errors++; $display("FAIL rnd_dp[%0d] got starts=%0d slat=%0d dlat=%0d exp 1/1/1", j, o.start_seen, o.start_lat, o.done_lat); end
      end
      if (eg >= 0) model_ptr = (eg + 1) % NREQ;
    end
    bus.req = '0;
  endtask

`ifdef GCD_WDT_EN
  task automatic test_watchdog();
    job_obs_t o;
    reset_dut();
    dp_model_en = 1'b0;
    set_op(1, 12, 8);
    do_job(4'b0010, 0, o);
    bus.req = '0;
    checks++; if (o.tmo || o.start_seen != 1 || o.rsp_lat != 1 + WDT) begin
      errors++; $display("FAIL t6_timing got starts=%0d lat=%0d exp 1/%0d", o.start_seen, o.rsp_lat, 1 + WDT); end
    checks++; if (o.err != 1 || o.res != 0 || o.id != 1) begin
      errors++; $display("FAIL t6_rsp got err=%0d res=%0d id=%0d exp 1/0/1", o.err, o.res, o.id); end
    checks++; if (o.valid_after != 0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL t6_idle got valid=%0d state=%0d exp 0/0", o.valid_after, dbg_state); end
    dp_model_en = 1'b1;
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.rsp_ready = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_bypass();
    test_backpressure();
    test_reset_mid_job();
    test_random();
`ifdef GCD_WDT_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
